// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encodings and default width for the serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_ctrl_fa_bit.sv
// rtl/serial_adder_ctrl_fa_bit.sv - combinational one-bit full-adder cell
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller sharing one full-adder cell over WIDTH cycles
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] pr;
    logic [WIDTH-1:0] pr_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cell_sum;
    logic             cell_cout;

    fa_bit u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (carry),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    // New result bit enters at the MSB; after WIDTH steps bit 0 has reached position 0.
    assign pr_next = WIDTH'({cell_sum, pr} >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            pr    <= '0;
            cnt   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    carry <= cell_cout;
                    pr    <= pr_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= pr_next;
                        cout  <= cell_cout;
                    end
                end
                // IDLE, DONE and the unused encoding all behave as "ready for a start".
                default: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        sa    <= a;
                        sb    <= b;
                        carry <= cin;
                        cnt   <= '0;
                        pr    <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
